ex_stage: RTL and testbench

- RV32I execute stage plus EX/MEM pipeline register.
- Consumes the 4-bit ALU control code produced by the ALU decoder (via ID/EX), together with operands, immediate and destination info.
- Selects operands with optional EX/MEM and WB forwarding, computes the ALU result, and registers the result for the MEM stage.
- Supports pipeline stall (hold) and flush (bubble insertion).

---
 rtl/alu_pkg.sv | 19 +
 rtl/ex_stage_if.sv | 43 ++++
 rtl/ex_stage_alu.sv | 34 +++
 rtl/ex_stage.sv | 98 +++++++++
 tb/tb_ex_stage.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ALU control encoding shared by the ALU decoder and the execute stage.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, WB bypass, pipeline control and EX/MEM outputs of the execute stage.
interface ex_stage_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  import alu_pkg::*;

  logic               id_valid;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic               alu_src;
  logic [RADDR_W-1:0] rs1_addr;
  logic [RADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]    rs1_data;
  logic [XLEN-1:0]    rs2_data;
  logic [XLEN-1:0]    imm;
  logic [RADDR_W-1:0] rd_addr;
  logic               reg_write;
  logic               stall;
  logic               flush;
  logic [RADDR_W-1:0] wb_rd_addr;
  logic               wb_reg_write;
  logic [XLEN-1:0]    wb_data;

  logic               exm_valid;
  logic [XLEN-1:0]    exm_result;
  logic [XLEN-1:0]    exm_store_data;
  logic [RADDR_W-1:0] exm_rd_addr;
  logic               exm_reg_write;
  logic               exm_zero;

  modport master (
    output id_valid, alu_ctrl, alu_src, rs1_addr, rs2_addr, rs1_data, rs2_data,
           imm, rd_addr, reg_write, stall, flush, wb_rd_addr, wb_reg_write, wb_data,
    input  exm_valid, exm_result, exm_store_data, exm_rd_addr, exm_reg_write, exm_zero
  );

  modport slave (
    input  id_valid, alu_ctrl, alu_src, rs1_addr, rs2_addr, rs1_data, rs2_data,
           imm, rd_addr, reg_write, stall, flush, wb_rd_addr, wb_reg_write, wb_data,
    output exm_valid, exm_result, exm_store_data, exm_rd_addr, exm_reg_write, exm_zero
  );

endinterface

// File: rtl/ex_stage_alu.sv
// Combinational RV32I ALU; unknown control codes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]       a,
  input  logic [XLEN-1:0]       b,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [XLEN-1:0]       result
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage with EX/MEM pipeline register, stall and flush.
// Operand bypassing from EX/MEM and WB is compiled in only when EX_FORWARD_EN is defined.
module ex_stage
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input logic      clk,
  input logic      rst,
  ex_stage_if.slave bus
);

  logic               exm_valid_q;
  logic [XLEN-1:0]    exm_result_q;
  logic [XLEN-1:0]    exm_store_data_q;
  logic [RADDR_W-1:0] exm_rd_addr_q;
  logic               exm_reg_write_q;
  logic               exm_zero_q;

  logic [XLEN-1:0]    op_a;
  logic [XLEN-1:0]    fwd_b;
  logic [XLEN-1:0]    op_b;
  logic [XLEN-1:0]    alu_result;

`ifdef EX_FORWARD_EN
  logic exm_fwd_ok;
  logic wb_fwd_ok;

  // x0 is never a bypass source; EX/MEM is newer than WB so it wins.
  assign exm_fwd_ok = exm_reg_write_q && exm_valid_q && (exm_rd_addr_q != '0);
  assign wb_fwd_ok  = bus.wb_reg_write && (bus.wb_rd_addr != '0);

  always_comb begin
    op_a = bus.rs1_data;
    if (exm_fwd_ok && (exm_rd_addr_q == bus.rs1_addr))
      op_a = exm_result_q;
    else if (wb_fwd_ok && (bus.wb_rd_addr == bus.rs1_addr))
      op_a = bus.wb_data;

    fwd_b = bus.rs2_data;
    if (exm_fwd_ok && (exm_rd_addr_q == bus.rs2_addr))
      fwd_b = exm_result_q;
    else if (wb_fwd_ok && (bus.wb_rd_addr == bus.rs2_addr))
      fwd_b = bus.wb_data;
  end
`else
  logic unused_fwd_inputs;

  // Without bypassing, hazards are resolved by stalling upstream.
  assign unused_fwd_inputs = ^{bus.wb_rd_addr, bus.wb_reg_write, bus.wb_data,
                               bus.rs1_addr, bus.rs2_addr};

  always_comb begin
    op_a  = bus.rs1_data;
    fwd_b = bus.rs2_data;
  end
`endif

  assign op_b = bus.alu_src ? bus.imm : fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .a        (op_a),
    .b        (op_b),
    .alu_ctrl (bus.alu_ctrl),
    .result   (alu_result)
  );

  // Flush only kills valid/write-enable; the data fields hold so the bubble is deterministic.
  always_ff @(posedge clk) begin
    if (rst) begin
      exm_valid_q      <= 1'b0;
      exm_result_q     <= '0;
      exm_store_data_q <= '0;
      exm_rd_addr_q    <= '0;
      exm_reg_write_q  <= 1'b0;
      exm_zero_q       <= 1'b0;
    end else if (bus.flush) begin
      exm_valid_q     <= 1'b0;
      exm_reg_write_q <= 1'b0;
    end else if (!bus.stall) begin
      exm_valid_q      <= bus.id_valid;
      exm_result_q     <= alu_result;
      exm_store_data_q <= fwd_b;
      exm_rd_addr_q    <= bus.rd_addr;
      exm_reg_write_q  <= bus.reg_write & bus.id_valid;
      exm_zero_q       <= (alu_result == '0);
    end
  end

  assign bus.exm_valid      = exm_valid_q;
  assign bus.exm_result     = exm_result_q;
  assign bus.exm_store_data = exm_store_data_q;
  assign bus.exm_rd_addr    = exm_rd_addr_q;
  assign bus.exm_reg_write  = exm_reg_write_q;
  assign bus.exm_zero       = exm_zero_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_ex_stage;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ex_stage_if #(.XLEN(32), .RADDR_W(5)) ifc ();

  ex_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural view of the EX/MEM register.
  logic        m_valid;
  logic [31:0] m_result;
  logic [31:0] m_store;
  logic [4:0]  m_rd;
  logic        m_rw;
  logic        m_zero;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd6:    return a << sh;
      4'd7:    return a >> sh;
      4'd8:    return 32'($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_operand(input logic [4:0] addr, input logic [31:0] data);
`ifdef EX_FORWARD_EN
    if (m_rw && m_valid && addr != 5'd0 && m_rd == addr) return m_result;
    if (ifc.wb_reg_write && ifc.wb_rd_addr != 5'd0 && ifc.wb_rd_addr == addr) return ifc.wb_data;
`endif
    return data;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  // Advance one edge, update the model from the pre-edge inputs, and compare every output.
  task automatic tick();
    logic [31:0] a, fb, b, r;
    a  = ref_operand(ifc.rs1_addr, ifc.rs1_data);
    fb = ref_operand(ifc.rs2_addr, ifc.rs2_data);
    b  = ifc.alu_src ? ifc.imm : fb;
    r  = ref_alu(ifc.alu_ctrl, a, b);
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_result = 0; m_store = 0; m_rd = 0; m_rw = 0; m_zero = 0;
    end else if (ifc.flush) begin
      m_valid = 0; m_rw = 0;
    end else if (!ifc.stall) begin
      m_valid  = ifc.id_valid;
      m_result = r;
      m_store  = fb;
      m_rd     = ifc.rd_addr;
      m_rw     = ifc.reg_write && ifc.id_valid;
      m_zero   = (r == 32'd0);
    end
    chk("valid",      32'(ifc.exm_valid),     32'(m_valid));
    chk("result",     ifc.exm_result,         m_result);
    chk("store_data", ifc.exm_store_data,     m_store);
    chk("rd_addr",    32'(ifc.exm_rd_addr),   32'(m_rd));
    chk("reg_write",  32'(ifc.exm_reg_write), 32'(m_rw));
    chk("zero",       32'(ifc.exm_zero),      32'(m_zero));
  endtask

  task automatic issue(input logic [3:0] op, input logic src, input logic [4:0] r1,
                       input logic [31:0] d1, input logic [4:0] r2, input logic [31:0] d2,
                       input logic [31:0] im, input logic [4:0] rd, input logic rw);
    ifc.id_valid  = 1'b1;
    ifc.alu_ctrl  = op;
    ifc.alu_src   = src;
    ifc.rs1_addr  = r1;
    ifc.rs1_data  = d1;
    ifc.rs2_addr  = r2;
    ifc.rs2_data  = d2;
    ifc.imm       = im;
    ifc.rd_addr   = rd;
    ifc.reg_write = rw;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    ifc.wb_reg_write = we;
    ifc.wb_rd_addr   = rd;
    ifc.wb_data      = d;
  endtask

  initial begin
    logic [31:0] held;
    checks   = 0;
    failures = 0;
    m_valid = 0; m_result = 0; m_store = 0; m_rd = 0; m_rw = 0; m_zero = 0;

    rst = 1'b1;
    issue(4'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    ifc.id_valid = 1'b0;
    ifc.stall    = 1'b0;
    ifc.flush    = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    chk("reset_valid",  32'(ifc.exm_valid),  32'd0);
    chk("reset_result", ifc.exm_result,      32'd0);

    // First instruction after reset: 5 + 7.
    rst = 1'b0;
    issue(ALU_ADD, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd6, 1'b1);
    tick();
    chk("add_result", ifc.exm_result, 32'd12);
    chk("add_valid",  32'(ifc.exm_valid), 32'd1);

    // Op sweep on the sign boundary; no register overlap with the previous rd.
    issue(ALU_SUB, 1'b0, 5'd10, 32'h8000_0000, 5'd11, 32'd1, 32'd0, 5'd12, 1'b0);
    tick(); chk("sub_min", ifc.exm_result, 32'h7FFF_FFFF);
    ifc.alu_ctrl = ALU_SLT;  tick(); chk("slt_min",  ifc.exm_result, 32'd1);
    ifc.alu_ctrl = ALU_SLTU; tick(); chk("sltu_min", ifc.exm_result, 32'd0);
    ifc.rs2_data = 32'd4;
    ifc.alu_ctrl = ALU_SRA;  tick(); chk("sra_4", ifc.exm_result, 32'hF800_0000);
    ifc.alu_ctrl = ALU_SRL;  tick(); chk("srl_4", ifc.exm_result, 32'h0800_0000);
    ifc.alu_ctrl = 4'hF;     tick(); chk("illegal_op", ifc.exm_result, 32'd0);
    chk("illegal_zero", 32'(ifc.exm_zero), 32'd1);

    // Back-to-back RAW on x3; rs1_data carries a stale 0x20.
    issue(ALU_ADD, 1'b0, 5'd1, 32'd2, 5'd2, 32'd3, 32'd0, 5'd3, 1'b1);
    tick();
    issue(ALU_ADD, 1'b1, 5'd3, 32'h20, 5'd0, 32'd0, 32'd10, 5'd4, 1'b1);
    tick();
`ifdef EX_FORWARD_EN
    chk("exm_forward", ifc.exm_result, 32'd15);
`else
    chk("no_forward", ifc.exm_result, 32'h2A);
`endif

    // EX/MEM x3=5 and WB x3=100 both pending: the younger EX/MEM value wins.
    issue(ALU_ADD, 1'b0, 5'd1, 32'd2, 5'd2, 32'd3, 32'd0, 5'd3, 1'b1);
    tick();
    issue(ALU_ADD, 1'b1, 5'd3, 32'd77, 5'd3, 32'd66, 32'd0, 5'd5, 1'b1);
    wb(1'b1, 5'd3, 32'd100);
    tick();
`ifdef EX_FORWARD_EN
    chk("double_hazard", ifc.exm_result, 32'd5);
    chk("double_store",  ifc.exm_store_data, 32'd5);
`else
    chk("double_hazard", ifc.exm_result, 32'd77);
    chk("double_store",  ifc.exm_store_data, 32'd66);
`endif
    wb(1'b0, 5'd0, 32'd0);

    // x0 must never be bypassed, even when EX/MEM and WB both target it.
    issue(ALU_ADD, 1'b0, 5'd1, 32'd4, 5'd2, 32'd5, 32'd0, 5'd0, 1'b1);
    tick();
    chk("x0_write", ifc.exm_result, 32'd9);
    issue(ALU_ADD, 1'b1, 5'd0, 32'd0, 5'd0, 32'd0, 32'd1, 5'd7, 1'b1);
    wb(1'b1, 5'd0, 32'd55);
    tick();
    chk("x0_guard", ifc.exm_result, 32'd1);
    chk("x0_store", ifc.exm_store_data, 32'd0);
    wb(1'b0, 5'd0, 32'd0);

    // Stall for three cycles while the inputs keep changing.
    issue(ALU_XOR, 1'b0, 5'd8, 32'h1234_5678, 5'd9, 32'h0F0F_0F0F, 32'd0, 5'd10, 1'b1);
    tick();
    held = m_result;
    ifc.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(4'($urandom_range(0, 9)), 1'($urandom), 5'd20, $urandom, 5'd21, $urandom,
            $urandom, 5'd22, 1'b1);
      tick();
      chk("stall_hold", ifc.exm_result, held);
    end

    // Stall and flush together: flush wins.
    ifc.flush = 1'b1;
    tick();
    chk("stall_flush_valid", 32'(ifc.exm_valid),     32'd0);
    chk("stall_flush_rw",    32'(ifc.exm_reg_write), 32'd0);
    chk("flush_hold_result", ifc.exm_result,         held);

    // Flush alone on a real writing instruction.
    ifc.stall = 1'b0;
    issue(ALU_OR, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 5'd3, 1'b1);
    tick();
    chk("flush_rw", 32'(ifc.exm_reg_write), 32'd0);
    ifc.flush = 1'b0;

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      issue(4'($urandom_range(0, 15)), 1'($urandom), 5'($urandom_range(0, 3)), $urandom,
            5'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
            5'($urandom_range(0, 3)), 1'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        ifc.rs1_data = 32'h8000_0000;
        ifc.rs2_data = ifc.rs1_data;
      end
      ifc.id_valid = ($urandom_range(0, 5) != 0);
      ifc.stall    = ($urandom_range(0, 7) == 0);
      ifc.flush    = ($urandom_range(0, 9) == 0);
      rst          = ($urandom_range(0, 49) == 0);
      wb(1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      tick();
    end

    // Reset mid-operation clears everything on the next edge.
    rst = 1'b0;
    ifc.stall = 1'b0;
    ifc.flush = 1'b0;
    issue(ALU_ADD, 1'b0, 5'd1, 32'd40, 5'd2, 32'd2, 32'd0, 5'd9, 1'b1);
    tick();
    chk("pre_rst_result", ifc.exm_result, 32'd42);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid",  32'(ifc.exm_valid), 32'd0);
    chk("mid_rst_result", ifc.exm_result,     32'd0);
    chk("mid_rst_rd",     32'(ifc.exm_rd_addr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
